// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared types and constants for the bit stream serializer
// Optional parity state is present only when SERIALIZER_PARITY_EN is defined.
package bit_serializer_pkg;

  localparam int WIDTH_DEFAULT = 8;
  // Wide enough for a bit index of the largest legal word (16 bits).
  localparam int CNT_W = $clog2(16);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/serializer_bit_counter.sv
// rtl/serializer_bit_counter.sv - loadable bit down-counter with terminal-count flag
module serializer_bit_counter
  import bit_serializer_pkg::*;
(
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec_en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Decrement saturates at zero so a held enable at terminal count never wraps.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - MSB-first parallel-to-serial converter
// Define SERIALIZER_PARITY_EN to append one even-parity bit after each word.
module bit_stream_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
)
(
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             LOAD,
  input  logic             ENABLE,
  output logic             READY,
  output logic             X,
  output logic             X_VALID,
  output logic             DONE
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_acc;
`endif

  assign cnt_load = (state == ST_IDLE) && LOAD;
  assign cnt_dec  = (state == ST_SHIFT) && ENABLE;

  serializer_bit_counter u_bit_counter (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .load       (cnt_load),
    .load_value (CNT_W'(WIDTH - 1)),
    .dec_en     (cnt_dec),
    .zero       (cnt_zero)
  );

  // The shift register MSB is the line itself, so it is cleared whenever the
  // FSM returns to idle and reloaded with the parity bit for the parity cycle.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      shreg <= '0;
`ifdef SERIALIZER_PARITY_EN
      parity_acc <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (LOAD) begin
            state <= ST_SHIFT;
            shreg <= DATA_IN;
`ifdef SERIALIZER_PARITY_EN
            parity_acc <= ^DATA_IN;
`endif
          end
        end
        ST_SHIFT: begin
          if (ENABLE) begin
            if (cnt_zero) begin
`ifdef SERIALIZER_PARITY_EN
              state <= ST_PARITY;
              shreg <= {parity_acc, {(WIDTH-1){1'b0}}};
`else
              state <= ST_IDLE;
              shreg <= '0;
`endif
            end else begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
          end
        end
`ifdef SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (ENABLE) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            parity_acc <= 1'b0;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          shreg <= '0;
        end
      endcase
    end
  end

  assign READY   = (state == ST_IDLE);
  assign X_VALID = (state != ST_IDLE);
  assign X       = shreg[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
  assign DONE    = (state == ST_PARITY);
`else
  assign DONE    = (state == ST_SHIFT) && cnt_zero;
`endif

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - scoreboard bench for bit_stream_serializer
// Honours SERIALIZER_PARITY_EN to expect the extra parity cycle.
module tb_bit_stream_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [7:0] DATA_IN;
  logic       LOAD;
  logic       ENABLE;
  logic       READY;
  logic       X;
  logic       X_VALID;
  logic       DONE;

  typedef struct packed {
    logic ready;
    logic xv;
    logic x;
    logic done;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // "10" detector applied to both the DUT stream and the expected stream.
  bit   det_on   = 1'b0;
  logic obs_prev = 1'b0;
  logic exp_prev = 1'b0;
  int   obs_hits = 0;
  int   exp_hits = 0;

  bit_stream_serializer #(.WIDTH(8)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .DATA_IN (DATA_IN),
    .LOAD    (LOAD),
    .ENABLE  (ENABLE),
    .READY   (READY),
    .X       (X),
    .X_VALID (X_VALID),
    .DONE    (DONE)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {ready,xv,x,done}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [7:0] d, input logic en, input string tag);
    obs_t       e;
    logic [3:0] o;
    logic       od;
    logic       ed;
    LOAD    = ld;
    DATA_IN = d;
    ENABLE  = en;
    @(posedge CLOCK);
    #1;
    o = {READY, X_VALID, X, DONE};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %b expected none", tag, o);
    end else begin
      e = exp_q.pop_front();
      check(tag, o, e);
      if (det_on) begin
        od = X_VALID & obs_prev & ~X;
        ed = e.xv & exp_prev & ~e.x;
        obs_prev = X_VALID & X;
        exp_prev = e.xv & e.x;
        obs_hits += int'(od);
        exp_hits += int'(ed);
        check({tag, "_det"}, {3'b000, od}, {3'b000, ed});
      end
    end
  endtask

  task automatic send_word(input logic [7:0] d, input int stall_at, input int stall_n,
                           input logic glitch, input string tag);
    obs_t b;
    for (int i = 0; i < 8; i++) begin
      b = {1'b0, 1'b1, d[7-i], (i == 7) && !PAR};
      exp_q.push_back(b);
      if (i + 1 == stall_at)
        for (int r = 0; r < stall_n; r++) exp_q.push_back(b);
    end
    if (PAR) exp_q.push_back({1'b0, 1'b1, ^d, 1'b1});
    exp_q.push_back(4'b1000);

    step(1'b1, d, 1'b1, tag);
    for (int i = 0; i < 8; i++) begin
      if (i + 1 == stall_at)
        for (int r = 0; r < stall_n; r++) step(glitch, 8'hFF, 1'b0, tag);
      step(glitch, 8'hFF, 1'b1, tag);
    end
    if (PAR) step(glitch, 8'hFF, 1'b1, tag);
    LOAD    = 1'b0;
    DATA_IN = 8'h00;
  endtask

  initial begin
    RESET   = 1'b1;
    LOAD    = 1'b0;
    ENABLE  = 1'b0;
    DATA_IN = 8'h00;
    #12;
    check("reset_state", {READY, X_VALID, X, DONE}, 4'b1000);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;

    exp_q.push_back(4'b1000);
    step(1'b0, 8'h00, 1'b1, "idle_no_load");

    send_word(8'hB4, 0, 0, 1'b0, "word_b4");
    send_word(8'h81, 2, 3, 1'b0, "stall_81");
    send_word(8'h00, 0, 0, 1'b1, "ignore_load_ff");
    send_word(8'h5A, 5, 2, 1'b0, "stall_5a");

    // Abort a word during its fifth bit with an asynchronous reset.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b0, 1'b1, 1'(8'hAA >> (7 - i)), 1'b0});
    end
    step(1'b1, 8'hAA, 1'b1, "abort_aa");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "abort_aa");
    #3;
    RESET = 1'b1;
    #1;
    check("async_reset", {READY, X_VALID, X, DONE}, 4'b1000);
    @(posedge CLOCK);
    #1;
    check("reset_hold", {READY, X_VALID, X, DONE}, 4'b1000);
    #1;
    RESET = 1'b0;
    send_word(8'h0F, 0, 0, 1'b0, "post_reset_0f");

    det_on   = 1'b1;
    obs_prev = 1'b0;
    exp_prev = 1'b0;
    send_word(8'h02, 0, 0, 1'b0, "detect_02");
    det_on = 1'b0;
    check("detect_hits", 4'(obs_hits), 4'(exp_hits));
    check("detect_count", 4'(obs_hits), 4'd1);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
